// File: rtl/uart_rx_unit_pkg.sv
// Shared MiniUart receive definitions: FSM state encoding, frame constants
// and the default oversample ratio.
package uart_rx_unit_pkg;

  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_unit_if.sv
// Serial line, oversample tick and bus-side status of the MiniUart receiver.
// master = the bus/baud side driving the unit, slave = the receive unit.
interface uart_rx_unit_if;
  import uart_rx_unit_pkg::*;

  logic                 rxd;
  logic                 en_rx;
  logic                 rd;
  logic [DATA_BITS-1:0] d_out;
  logic                 rs;
  logic                 fe;
  logic                 ovr;

  modport master (output rxd, en_rx, rd, input d_out, rs, fe, ovr);
  modport slave  (input rxd, en_rx, rd, output d_out, rs, fe, ovr);
endinterface

// File: rtl/uart_rx_unit_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd line, plus the previous
// tick-sampled value used by the FSM for falling-edge detection.
// Everything resets to 1 so an idle-high line never looks like an edge.
module uart_rx_unit_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic prev_o
);

  logic s1_q, s2_q, prev_q;

  // Metastability chain; prev only moves on oversample ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q <= rxd_i;
      s2_q <= s1_q;
      if (en_i) prev_q <= s2_q;
    end
  end

  assign rxd_s_o = s2_q;
  assign prev_o  = prev_q;

endmodule

// File: rtl/uart_rx_unit.sv
// MiniUart receive unit: 8N1 deserialiser with byte buffer and status flags.
// Optional feature macro: UART_RX_OVERRUN_EN -- when defined, a good stop
// while a previous byte is still unread (and not being read) sets sticky ovr.
// When undefined, ovr is tied low and the newer byte overwrites silently.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_unit_if.slave rx_if
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rs_q, rs_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 rxd_s, prev_s;
  logic                 good_stop, bad_stop;

  uart_rx_unit_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .en_i    (rx_if.en_rx),
    .rxd_i   (rx_if.rxd),
    .rxd_s_o (rxd_s),
    .prev_o  (prev_s)
  );

  // State, counters, shift register and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      rs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      rs_q    <= rs_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing on oversample ticks; flag update with set-over-clear priority
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    dout_d    = dout_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;

    if (rx_if.en_rx) begin
      case (state_q)
        RX_IDLE: begin
          tick_d = '0;
          if (!rxd_s && prev_s) state_d = RX_START;
        end
        RX_START: begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            // Line back high by mid start bit means it was only a glitch
            state_d = rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        RX_DATA: begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            sh_d   = {rxd_s, sh_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) state_d = RX_STOP;
            else                   bit_d   = bit_q + 3'd1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        RX_STOP: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            state_d = RX_IDLE;
            if (rxd_s) begin
              good_stop = 1'b1;
              dout_d    = sh_q;
            end else begin
              bad_stop  = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    rs_d = good_stop ? 1'b1 : (rx_if.rd ? 1'b0 : rs_q);
    fe_d = bad_stop  ? 1'b1 : (rx_if.rd ? 1'b0 : fe_q);
`ifdef UART_RX_OVERRUN_EN
    ovr_d = (good_stop && rs_q && !rx_if.rd) ? 1'b1 : (rx_if.rd ? 1'b0 : ovr_q);
`else
    ovr_d = 1'b0;
`endif
  end

  assign rx_if.d_out = dout_q;
  assign rx_if.rs    = rs_q;
  assign rx_if.fe    = fe_q;
`ifdef UART_RX_OVERRUN_EN
  assign rx_if.ovr   = ovr_q;
`else
  assign rx_if.ovr   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at OVERSAMPLE=16 with en_rx high every clk.
module tb_uart_rx_unit;

`ifdef UART_RX_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  logic rs_prev = 1'b0;

  uart_rx_unit_if rx_if ();

  uart_rx_unit #(.OVERSAMPLE(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rs_prev <= rx_if.rs;
    if (rx_if.rs && !rs_prev) rise_cyc <= cyc;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         kind;   // 0 frame, 1 glitch, 2 rd pulse
    logic [7:0] data;
    logic       stop;
    logic [7:0] e_dout;
    logic       e_rs;
    logic       e_fe;
    logic       e_ovr;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Drives the first nclk oversample periods of a frame, rd high at index rd_at
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int nclk, input int rd_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int n = 0; n < nclk; n++) begin
      rx_if.rxd = fr[n / 16];
      rx_if.rd  = (n == rd_at);
      @(negedge clk);
    end
    rx_if.rd  = 1'b0;
    rx_if.rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_if.rxd = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic r, input logic f, input logic o);
    chk({tag, ".d_out"}, rx_if.d_out, d);
    chk({tag, ".rs"},    {7'd0, rx_if.rs},  {7'd0, r});
    chk({tag, ".fe"},    {7'd0, rx_if.fe},  {7'd0, f});
    chk({tag, ".ovr"},   {7'd0, rx_if.ovr}, {7'd0, o});
  endtask

  vec_t vecs[8];
  int   start_cyc;
  int   lat;

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{0, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{0, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0, OVR_EXP};
    vecs[7] = '{2, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};

    rx_if.rxd   = 1'b1;
    rx_if.en_rx = 1'b1;
    rx_if.rd    = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 8; i++) begin
      case (vecs[i].kind)
        0: begin
          start_cyc = cyc;
          drive_frame(vecs[i].data, vecs[i].stop, 160, -1);
          idle(4);
          if (i == 0) begin
            lat = rise_cyc - start_cyc;
            checks++;
            if (lat < 153 || lat > 157) begin
              errors++;
              $display("FAIL latency act=%0d exp=155(+-2)", lat);
            end
          end
        end
        1: begin
          rx_if.rxd = 1'b0;
          repeat (5) @(negedge clk);
          idle(40);
        end
        default: begin
          rx_if.rd = 1'b1;
          @(negedge clk);
          rx_if.rd = 1'b0;
          @(negedge clk);
        end
      endcase
      chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_rs, vecs[i].e_fe, vecs[i].e_ovr);
    end

    // rd on the same edge as a good stop: set wins, no overrun
    drive_frame(8'h33, 1'b1, 160, -1);
    idle(4);
    chk_all("pre_rd_same", 8'h33, 1'b1, 1'b0, 1'b0);
    drive_frame(8'h77, 1'b1, 160, 154);
    idle(4);
    chk_all("rd_same", 8'h77, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of data bit 4, then a clean frame
    drive_frame(8'hC3, 1'b1, 88, -1);
    #3 rst = 1'b1;
    rx_if.rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(200);
    chk_all("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    drive_frame(8'h5A, 1'b1, 160, -1);
    idle(4);
    chk_all("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
